// File: rtl/alu_mem_skid_stage.sv
// ALU->MEM pipeline register with valid/ready handshake and a two-entry skid
// buffer (main entry drives the outputs, skid entry absorbs one extra push
// while MEM stalls). All outputs are registered. Define ALU_MEM_FWD_EN to add
// a combinational forwarding tap over the in-flight entries.
module alu_mem_skid_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              resetIn,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inData,
  input  logic              inWriteEnable,
  input  logic [ADDR_W-1:0] inWriteBackAddr,
  input  logic              flushIn,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic              outWriteEnable,
  output logic [ADDR_W-1:0] outWriteBackAddr,
  output logic              resetOut,
`ifdef ALU_MEM_FWD_EN
  input  logic [ADDR_W-1:0] fwdAddrIn,
  output logic              fwdHitOut,
  output logic [DATA_W-1:0] fwdDataOut,
`endif
  output logic [1:0]        occupancy
);

  // Main entry (head toward MEM)
  logic              r_mainValid;
  logic [DATA_W-1:0] r_mainData;
  logic              r_mainWe;
  logic [ADDR_W-1:0] r_mainAddr;
  // Skid entry (younger)
  logic              r_skidValid;
  logic [DATA_W-1:0] r_skidData;
  logic              r_skidWe;
  logic [ADDR_W-1:0] r_skidAddr;
  // Registered status
  logic              r_inReady;
  logic [1:0]        r_occupancy;
  logic              r_resetOut;

  logic              w_pop, w_push;
  logic              w_nxtMainValid, w_nxtMainWe, w_nxtSkidValid, w_nxtSkidWe;
  logic [DATA_W-1:0] w_nxtMainData, w_nxtSkidData;
  logic [ADDR_W-1:0] w_nxtMainAddr, w_nxtSkidAddr;

  assign w_pop  = r_mainValid & outReady;
  assign w_push = inValid & r_inReady;

  // Next-state of both entries: flush wins, then skid refills main before
  // any new input so ordering stays FIFO.
  always_comb begin
    w_nxtMainValid = r_mainValid;
    w_nxtMainData  = r_mainData;
    w_nxtMainWe    = r_mainWe;
    w_nxtMainAddr  = r_mainAddr;
    w_nxtSkidValid = r_skidValid;
    w_nxtSkidData  = r_skidData;
    w_nxtSkidWe    = r_skidWe;
    w_nxtSkidAddr  = r_skidAddr;
    if (flushIn) begin
      // Payload registers hold; only the valids and the head write-enable drop
      w_nxtMainValid = 1'b0;
      w_nxtMainWe    = 1'b0;
      w_nxtSkidValid = 1'b0;
    end else if (!r_mainValid || w_pop) begin
      if (r_skidValid) begin
        w_nxtMainValid = 1'b1;
        w_nxtMainData  = r_skidData;
        w_nxtMainWe    = r_skidWe;
        w_nxtMainAddr  = r_skidAddr;
        w_nxtSkidValid = 1'b0;
      end else if (w_push) begin
        w_nxtMainValid = 1'b1;
        w_nxtMainData  = inData;
        w_nxtMainWe    = inWriteEnable;
        w_nxtMainAddr  = inWriteBackAddr;
      end else begin
        w_nxtMainValid = 1'b0;
        w_nxtMainWe    = 1'b0;
      end
    end else if (w_push) begin
      w_nxtSkidValid = 1'b1;
      w_nxtSkidData  = inData;
      w_nxtSkidWe    = inWriteEnable;
      w_nxtSkidAddr  = inWriteBackAddr;
    end
  end

  // Entry storage and registered status; reset empties everything at once
  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      r_mainValid <= 1'b0;
      r_mainData  <= '0;
      r_mainWe    <= 1'b0;
      r_mainAddr  <= '0;
      r_skidValid <= 1'b0;
      r_skidData  <= '0;
      r_skidWe    <= 1'b0;
      r_skidAddr  <= '0;
      r_inReady   <= 1'b1;
      r_occupancy <= 2'd0;
    end else begin
      r_mainValid <= w_nxtMainValid;
      r_mainData  <= w_nxtMainData;
      r_mainWe    <= w_nxtMainWe;
      r_mainAddr  <= w_nxtMainAddr;
      r_skidValid <= w_nxtSkidValid;
      r_skidData  <= w_nxtSkidData;
      r_skidWe    <= w_nxtSkidWe;
      r_skidAddr  <= w_nxtSkidAddr;
      r_inReady   <= ~w_nxtSkidValid;
      r_occupancy <= {1'b0, w_nxtMainValid} + {1'b0, w_nxtSkidValid};
    end
  end

  // RAM reset indication: set with reset, cleared on the first edge after it
  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) r_resetOut <= 1'b1;
    else         r_resetOut <= 1'b0;
  end

  assign inReady          = r_inReady;
  assign outValid         = r_mainValid;
  assign outData          = r_mainData;
  assign outWriteEnable   = r_mainWe & r_mainValid;
  assign outWriteBackAddr = r_mainAddr;
  assign occupancy        = r_occupancy;
  assign resetOut         = r_resetOut;

`ifdef ALU_MEM_FWD_EN
  // Forwarding lookup: younger skid entry wins over main; register 0 never hits
  always_comb begin
    fwdHitOut  = 1'b0;
    fwdDataOut = '0;
    if (fwdAddrIn != '0) begin
      if (r_skidValid && r_skidWe && (r_skidAddr == fwdAddrIn)) begin
        fwdHitOut  = 1'b1;
        fwdDataOut = r_skidData;
      end else if (r_mainValid && r_mainWe && (r_mainAddr == fwdAddrIn)) begin
        fwdHitOut  = 1'b1;
        fwdDataOut = r_mainData;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_mem_skid_stage.sv
// Bench for alu_mem_skid_stage: directed vector table, hand-written reset /
// stream sequences and randomized traffic against a queue-based FIFO model.
module tb_alu_mem_skid_stage;
  logic        clk = 1'b0;
  logic        resetIn;
  logic        inValid, inWriteEnable, flushIn, outReady;
  logic [31:0] inData;
  logic [4:0]  inWriteBackAddr;
  logic        inReady, outValid, outWriteEnable, resetOut;
  logic [31:0] outData;
  logic [4:0]  outWriteBackAddr;
  logic [1:0]  occupancy;
`ifdef ALU_MEM_FWD_EN
  logic [4:0]  fwdAddrIn;
  logic        fwdHitOut;
  logic [31:0] fwdDataOut;
`endif

  int checks = 0;
  int errors = 0;

  alu_mem_skid_stage dut (
    .clk(clk), .resetIn(resetIn), .inValid(inValid), .inReady(inReady),
    .inData(inData), .inWriteEnable(inWriteEnable),
    .inWriteBackAddr(inWriteBackAddr), .flushIn(flushIn),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .outWriteEnable(outWriteEnable), .outWriteBackAddr(outWriteBackAddr),
    .resetOut(resetOut),
`ifdef ALU_MEM_FWD_EN
    .fwdAddrIn(fwdAddrIn), .fwdHitOut(fwdHitOut), .fwdDataOut(fwdDataOut),
`endif
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a FIFO of at most two entries
  typedef struct { logic [31:0] d; logic we; logic [4:0] a; } ent_t;
  ent_t mq[$];

  task automatic model_tick();
    bit can_take, pop, push;
    can_take = (mq.size() < 2);
    if (flushIn) mq.delete();
    else begin
      pop  = (mq.size() > 0) && outReady;
      push = inValid && can_take;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back('{inData, inWriteEnable, inWriteBackAddr});
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".outValid"}, 32'(outValid), 32'(mq.size() > 0));
    check({tag, ".occ"}, 32'(occupancy), 32'(mq.size()));
    check({tag, ".inReady"}, 32'(inReady), 32'(mq.size() < 2));
    if (mq.size() > 0) begin
      check({tag, ".data"}, outData, mq[0].d);
      check({tag, ".we"}, 32'(outWriteEnable), 32'(mq[0].we));
      check({tag, ".addr"}, 32'(outWriteBackAddr), 32'(mq[0].a));
    end else begin
      check({tag, ".we"}, 32'(outWriteEnable), 32'd0);
    end
  endtask

  // Advance one clock with the model in lock-step; inputs change at edge+1
  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic we,
                       input logic [4:0] a, input logic ordy, input logic fl);
    inValid = iv; inData = d; inWriteEnable = we; inWriteBackAddr = a;
    outReady = ordy; flushIn = fl;
  endtask

  typedef struct {
    logic iv; logic [31:0] d; logic we; logic [4:0] a; logic ordy; logic fl;
    logic ev; logic [31:0] ed; logic ewe; logic [4:0] ea; logic [1:0] eocc;
    logic erdy; logic chkd;
  } vec_t;
  vec_t vt[11];

  initial begin
    // Vectors from an empty stage; expectations are the state after the edge
    vt[0]  = '{1'b1, 32'hA,  1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 32'hA,  1'b1, 5'd1, 2'd1, 1'b1, 1'b1};
    vt[1]  = '{1'b1, 32'hB,  1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 32'hA,  1'b1, 5'd1, 2'd2, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 32'hC,  1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 32'hA,  1'b1, 5'd1, 2'd2, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 32'hC,  1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 32'hB,  1'b1, 5'd2, 2'd1, 1'b1, 1'b1};
    vt[4]  = '{1'b1, 32'hC,  1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 32'hC,  1'b1, 5'd3, 2'd1, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 5'd0, 2'd0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 32'h70, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1, 32'h70, 1'b0, 5'd7, 2'd1, 1'b1, 1'b1};
    vt[7]  = '{1'b1, 32'h71, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 32'h71, 1'b1, 5'd7, 2'd1, 1'b1, 1'b1};
    vt[8]  = '{1'b1, 32'h11, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 32'h71, 1'b1, 5'd7, 2'd2, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 32'h55, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 2'd0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 32'h0,  1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 5'd0, 2'd0, 1'b1, 1'b0};

    // Power-on reset
    resetIn = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
`ifdef ALU_MEM_FWD_EN
    fwdAddrIn = '0;
`endif
    #2;
    check("rst.outValid", 32'(outValid), 0);
    check("rst.outData", outData, 0);
    check("rst.addr", 32'(outWriteBackAddr), 0);
    check("rst.we", 32'(outWriteEnable), 0);
    check("rst.occ", 32'(occupancy), 0);
    check("rst.inReady", 32'(inReady), 1);
    check("rst.resetOut", 32'(resetOut), 1);
    @(posedge clk); #3;
    resetIn = 1'b0;
    #1 check("rst.resetOutHeld", 32'(resetOut), 1);
    @(posedge clk); #1;
    check("rst.resetOutClr", 32'(resetOut), 0);
    mq.delete();

    // Directed table
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].iv, vt[i].d, vt[i].we, vt[i].a, vt[i].ordy, vt[i].fl);
      tick();
      check($sformatf("vec%0d.outValid", i), 32'(outValid), 32'(vt[i].ev));
      check($sformatf("vec%0d.we", i), 32'(outWriteEnable), 32'(vt[i].ewe));
      check($sformatf("vec%0d.occ", i), 32'(occupancy), 32'(vt[i].eocc));
      check($sformatf("vec%0d.inReady", i), 32'(inReady), 32'(vt[i].erdy));
      if (vt[i].chkd) begin
        check($sformatf("vec%0d.data", i), outData, vt[i].ed);
        check($sformatf("vec%0d.addr", i), 32'(outWriteBackAddr), 32'(vt[i].ea));
      end
    end

    // Stream of 8 with MEM always ready: one per cycle, 1-cycle latency
    for (int i = 1; i <= 8; i++) begin
      drive(1, 32'(i), 1, 5'(i), 1, 0);
      tick();
      check($sformatf("stream%0d.outValid", i), 32'(outValid), 1);
      check($sformatf("stream%0d.data", i), outData, 32'(i));
      check($sformatf("stream%0d.occLe1", i), 32'(occupancy <= 2'd1), 1);
    end
    drive(0, 0, 0, 0, 1, 0);
    tick();
    check_model("drain");

`ifdef ALU_MEM_FWD_EN
    // Skid holds the younger write to the same register
    drive(1, 32'h10, 1, 5'd3, 0, 0); tick();
    drive(1, 32'h20, 1, 5'd3, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    fwdAddrIn = 5'd3; #1;
    check("fwd.hit3", 32'(fwdHitOut), 1);
    check("fwd.data3", fwdDataOut, 32'h20);
    fwdAddrIn = 5'd0; #1;
    check("fwd.hit0", 32'(fwdHitOut), 0);
    check("fwd.data0", fwdDataOut, 0);
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0);
`endif

    // Mid-stream reset with two entries held
    drive(1, 32'hD1, 1, 5'd4, 0, 0); tick();
    drive(1, 32'hD2, 1, 5'd5, 0, 0); tick();
    check("midrst.occPre", 32'(occupancy), 2);
    drive(0, 0, 0, 0, 0, 0);
    #2 resetIn = 1'b1;
    #1;
    check("midrst.outValid", 32'(outValid), 0);
    check("midrst.occ", 32'(occupancy), 0);
    check("midrst.inReady", 32'(inReady), 1);
    check("midrst.resetOut", 32'(resetOut), 1);
    check("midrst.outData", outData, 0);
    #1 resetIn = 1'b0;
    mq.delete();
    @(posedge clk); #1;
    check("midrst.resetOutClr", 32'(resetOut), 0);
    check_model("midrst.after");

    // Randomized traffic against the FIFO model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0));
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
